// File: rtl/sram_pixel_arbiter.sv
// Arbiter for the single 16-bit async SRAM: VGA pixel fetches share the
// bus with drawing-FSM read/write requests. Address is packed {X[9:0],Y[9:0]}.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | bus parked (OE_N=1, WE_N=1, DQ_OE=0), arbitration each cycle
// RD_ADDR  | read address and OE_N=0 driven, SRAM access time
// RD_CAP   | same drive held, iSRAM_DQ captured at end of cycle
// WR_SETUP | address and data driven, WE_N still high
// WR_PULSE | WE_N low for exactly one cycle
// WR_HOLD  | WE_N high again, address and data held
module sram_pixel_arbiter #(
  parameter int H_ACT        = 640,
  parameter int V_ACT        = 480,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iVGA_REQ,
  input  logic [9:0]  iVGA_X,
  input  logic [9:0]  iVGA_Y,
  output logic [15:0] oVGA_DATA,
  output logic        oVGA_VALID,
  output logic        oVGA_OVR,
  input  logic        iREQ,
  input  logic        iWE,
  input  logic [9:0]  iX,
  input  logic [9:0]  iY,
  input  logic [15:0] iWDATA,
  output logic        oACK,
  output logic        oDONE,
  output logic        oERR,
  output logic [15:0] oRDATA,
  output logic [19:0] oSRAM_ADDR,
  output logic        oSRAM_WE_N,
  output logic        oSRAM_OE_N,
  output logic [15:0] oSRAM_DQ,
  output logic        oSRAM_DQ_OE,
  input  logic [15:0] iSRAM_DQ
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [9:0] X_LIM = 10'(H_ACT);
  localparam logic [9:0] Y_LIM = 10'(V_ACT);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic          vga_pend_q, vga_pend_d;
  logic [9:0]    vga_x_q, vga_x_d;
  logic [9:0]    vga_y_q, vga_y_d;
  logic          vga_ovr_q, vga_ovr_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          op_vga_q, op_vga_d;
  logic [19:0]   addr_q, addr_d;
  logic [15:0]   dq_q, dq_d;
  logic          dq_oe_q, dq_oe_d;
  logic          we_n_q, we_n_d;
  logic          oe_n_q, oe_n_d;
  logic          vga_valid_q, vga_valid_d;
  logic [15:0]   vga_data_q, vga_data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   rdata_q, rdata_d;

  logic          ack_c;
  logic          grant_vga;
  logic          vga_avail;
  logic          client_oor;

  // All state and every SRAM control line is a flop so reset parks the bus immediately.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= IDLE;
      vga_pend_q  <= 1'b0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_ovr_q   <= 1'b0;
      starve_q    <= '0;
      op_vga_q    <= 1'b0;
      addr_q      <= '0;
      dq_q        <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      vga_valid_q <= 1'b0;
      vga_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      vga_pend_q  <= vga_pend_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_ovr_q   <= vga_ovr_d;
      starve_q    <= starve_d;
      op_vga_q    <= op_vga_d;
      addr_q      <= addr_d;
      dq_q        <= dq_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      vga_valid_q <= vga_valid_d;
      vga_data_q  <= vga_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  // Arbitration, next state, next bus drive and the VGA pending slot.
  always_comb begin
    state_d     = state_q;
    vga_pend_d  = vga_pend_q;
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_ovr_d   = vga_ovr_q;
    starve_d    = starve_q;
    op_vga_d    = op_vga_q;
    addr_d      = addr_q;
    dq_d        = dq_q;
    dq_oe_d     = dq_oe_q;
    we_n_d      = we_n_q;
    oe_n_d      = oe_n_q;
    vga_data_d  = vga_data_q;
    rdata_d     = rdata_q;
    vga_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ack_c       = 1'b0;
    grant_vga   = 1'b0;
    // A strobe arriving while IDLE is served the same cycle, so it beats a
    // simultaneous client request unless the client is already starved.
    vga_avail   = vga_pend_q | iVGA_REQ;
    client_oor  = (iX >= X_LIM) || (iY >= Y_LIM);

    case (state_q)
      IDLE: begin
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        if (iREQ && ((starve_q == STARVE_MAX) || !vga_avail)) begin
          ack_c    = 1'b1;
          starve_d = '0;
          if (client_oor) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            addr_d   = {iX, iY};
            op_vga_d = 1'b0;
            if (iWE) begin
              dq_d    = iWDATA;
              dq_oe_d = 1'b1;
              state_d = WR_SETUP;
            end else begin
              oe_n_d  = 1'b0;
              state_d = RD_ADDR;
            end
          end
        end else if (vga_avail) begin
          grant_vga = 1'b1;
          starve_d  = iREQ ? starve_q + 1'b1 : '0;
          addr_d    = vga_pend_q ? {vga_x_q, vga_y_q} : {iVGA_X, iVGA_Y};
          oe_n_d    = 1'b0;
          op_vga_d  = 1'b1;
          state_d   = RD_ADDR;
        end
      end
      RD_ADDR: state_d = RD_CAP;
      RD_CAP: begin
        oe_n_d  = 1'b1;
        state_d = IDLE;
        if (op_vga_q) begin
          vga_valid_d = 1'b1;
          vga_data_d  = iSRAM_DQ;
        end else begin
          done_d  = 1'b1;
          rdata_d = iSRAM_DQ;
        end
      end
      WR_SETUP: begin
        we_n_d  = 1'b0;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        we_n_d  = 1'b1;
        state_d = WR_HOLD;
      end
      WR_HOLD: begin
        dq_oe_d = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    // A grant consumes the held entry; a strobe in that cycle survives only
    // if the grant took the older entry rather than the strobe itself.
    if (grant_vga) begin
      vga_pend_d = vga_pend_q & iVGA_REQ;
    end else if (iVGA_REQ) begin
      vga_pend_d = 1'b1;
      if (vga_pend_q) vga_ovr_d = 1'b1;
    end
    if (iVGA_REQ) begin
      vga_x_d = iVGA_X;
      vga_y_d = iVGA_Y;
    end
  end

  assign oACK        = ack_c;
  assign oDONE       = done_q;
  assign oERR        = err_q;
  assign oRDATA      = rdata_q;
  assign oVGA_DATA   = vga_data_q;
  assign oVGA_VALID  = vga_valid_q;
  assign oVGA_OVR    = vga_ovr_q;
  assign oSRAM_ADDR  = addr_q;
  assign oSRAM_WE_N  = we_n_q;
  assign oSRAM_OE_N  = oe_n_q;
  assign oSRAM_DQ    = dq_q;
  assign oSRAM_DQ_OE = dq_oe_q;

endmodule

// File: tb/tb_sram_pixel_arbiter.sv
// Directed bench for sram_pixel_arbiter with a behavioural async SRAM.
module tb_sram_pixel_arbiter;

  logic        iCLK;
  logic        iRST;
  logic        iVGA_REQ;
  logic [9:0]  iVGA_X;
  logic [9:0]  iVGA_Y;
  logic [15:0] oVGA_DATA;
  logic        oVGA_VALID;
  logic        oVGA_OVR;
  logic        iREQ;
  logic        iWE;
  logic [9:0]  iX;
  logic [9:0]  iY;
  logic [15:0] iWDATA;
  logic        oACK;
  logic        oDONE;
  logic        oERR;
  logic [15:0] oRDATA;
  logic [19:0] oSRAM_ADDR;
  logic        oSRAM_WE_N;
  logic        oSRAM_OE_N;
  logic [15:0] oSRAM_DQ;
  logic        oSRAM_DQ_OE;
  logic [15:0] iSRAM_DQ;

  int checks = 0;
  int failures = 0;

  sram_pixel_arbiter dut (
    .iCLK(iCLK), .iRST(iRST),
    .iVGA_REQ(iVGA_REQ), .iVGA_X(iVGA_X), .iVGA_Y(iVGA_Y),
    .oVGA_DATA(oVGA_DATA), .oVGA_VALID(oVGA_VALID), .oVGA_OVR(oVGA_OVR),
    .iREQ(iREQ), .iWE(iWE), .iX(iX), .iY(iY), .iWDATA(iWDATA),
    .oACK(oACK), .oDONE(oDONE), .oERR(oERR), .oRDATA(oRDATA),
    .oSRAM_ADDR(oSRAM_ADDR), .oSRAM_WE_N(oSRAM_WE_N), .oSRAM_OE_N(oSRAM_OE_N),
    .oSRAM_DQ(oSRAM_DQ), .oSRAM_DQ_OE(oSRAM_DQ_OE), .iSRAM_DQ(iSRAM_DQ)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // SRAM model: preloads and DUT writes both land on the rising clock edge.
  logic [15:0] mem [0:1048575];
  logic        pl_en = 1'b0;
  logic [19:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge iCLK) begin
    if (pl_en) mem[pl_addr] = pl_data;
    if (!oSRAM_WE_N && oSRAM_DQ_OE) mem[oSRAM_ADDR] = oSRAM_DQ;
  end

  assign iSRAM_DQ = oSRAM_OE_N ? 16'h0000 : mem[oSRAM_ADDR];

  // Bus invariants sampled every cycle outside reset.
  int          viol = 0;
  logic        prev_we_low = 1'b0;
  logic [19:0] prev_addr = '0;
  always @(negedge iCLK) begin
    if (!iRST) begin
      if (!oSRAM_WE_N && !oSRAM_OE_N) viol++;
      if (oSRAM_DQ_OE && !oSRAM_OE_N) viol++;
      if (!oSRAM_WE_N && !oSRAM_DQ_OE) viol++;
      if (!oSRAM_WE_N && prev_we_low && (oSRAM_ADDR != prev_addr)) viol++;
    end
    prev_we_low = !oSRAM_WE_N;
    prev_addr   = oSRAM_ADDR;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic preload(input logic [19:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge iCLK);
    #1 pl_en = 1'b0;
    @(negedge iCLK);
  endtask

  // Issues one client op at the current negedge (cycle 0) and observes
  // cycles 1..10. Returns at a negedge with the DUT idle.
  task automatic run_client(input logic we, input logic [9:0] x, input logic [9:0] y,
                            input logic [15:0] wd,
                            output logic ack, output int done_cyc, output logic err,
                            output logic [15:0] rdata, output int we_first, output int we_cnt,
                            output int oe_cnt, output logic [19:0] addr_we,
                            output logic setup_ok, output logic hold_ok);
    ack = 1'b0; done_cyc = -1; err = 1'b0; rdata = '0;
    we_first = -1; we_cnt = 0; oe_cnt = 0; addr_we = '0;
    setup_ok = 1'b0; hold_ok = 1'b0;
    iREQ = 1'b1; iWE = we; iX = x; iY = y; iWDATA = wd;
    #1 ack = oACK;
    @(negedge iCLK);
    iREQ = 1'b0; iWE = 1'b0; iX = '0; iY = '0; iWDATA = '0;
    for (int c = 1; c <= 10; c++) begin
      if (!oSRAM_WE_N) begin
        if (we_first < 0) begin
          we_first = c;
          addr_we  = oSRAM_ADDR;
        end
        we_cnt++;
      end
      if (!oSRAM_OE_N) oe_cnt++;
      if (oDONE && done_cyc < 0) begin
        done_cyc = c;
        err      = oERR;
        rdata    = oRDATA;
      end
      if (c == 1) setup_ok = oSRAM_WE_N && oSRAM_DQ_OE && (oSRAM_DQ == wd) && (oSRAM_ADDR == {x, y});
      if (c == 3) hold_ok  = oSRAM_WE_N && oSRAM_DQ_OE && (oSRAM_DQ == wd) && (oSRAM_ADDR == {x, y});
      @(negedge iCLK);
    end
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    #2;
    checks++; if (oSRAM_WE_N !== 1'b1) begin failures++; $display("FAIL reset_we_n got=%b exp=1", oSRAM_WE_N); end
    checks++; if (oSRAM_OE_N !== 1'b1) begin failures++; $display("FAIL reset_oe_n got=%b exp=1", oSRAM_OE_N); end
    checks++; if (oSRAM_DQ_OE !== 1'b0) begin failures++; $display("FAIL reset_dq_oe got=%b exp=0", oSRAM_DQ_OE); end
    checks++; if (oSRAM_ADDR !== 20'h0) begin failures++; $display("FAIL reset_addr got=%h exp=00000", oSRAM_ADDR); end
    checks++;
    if ({oVGA_DATA, oRDATA, oSRAM_DQ} !== 48'h0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", oVGA_DATA, oRDATA, oSRAM_DQ);
    end
    checks++;
    if ({oVGA_VALID, oVGA_OVR, oACK, oDONE, oERR} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {oVGA_VALID, oVGA_OVR, oACK, oDONE, oERR});
    end
    @(negedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    @(negedge iCLK);
  endtask

  task automatic test_vga_fetch();
    int oe_first, oe_cnt, valid_cyc, vcnt;
    logic [19:0] addr_oe;
    logic [15:0] vdata;
    oe_first = -1; oe_cnt = 0; valid_cyc = -1; vcnt = 0; addr_oe = '0; vdata = '0;
    preload(20'h01407, 16'hABCD);
    iVGA_REQ = 1'b1; iVGA_X = 10'd5; iVGA_Y = 10'd7;
    @(negedge iCLK);
    iVGA_REQ = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (!oSRAM_OE_N) begin
        if (oe_first < 0) begin oe_first = c; addr_oe = oSRAM_ADDR; end
        oe_cnt++;
      end
      if (oVGA_VALID) begin
        vcnt++;
        if (valid_cyc < 0) begin valid_cyc = c; vdata = oVGA_DATA; end
      end
      @(negedge iCLK);
    end
    checks++; if (oe_first !== 1) begin failures++; $display("FAIL vga_oe_start got=%0d exp=1", oe_first); end
    checks++; if (oe_cnt !== 2) begin failures++; $display("FAIL vga_oe_cycles got=%0d exp=2", oe_cnt); end
    checks++; if (addr_oe !== 20'h01407) begin failures++; $display("FAIL vga_addr got=%h exp=01407", addr_oe); end
    checks++; if (valid_cyc !== 3) begin failures++; $display("FAIL vga_latency got=%0d exp=3", valid_cyc); end
    checks++; if (vcnt !== 1) begin failures++; $display("FAIL vga_valid_count got=%0d exp=1", vcnt); end
    checks++; if (vdata !== 16'hABCD) begin failures++; $display("FAIL vga_data got=%h exp=abcd", vdata); end
    checks++; if (oVGA_OVR !== 1'b0) begin failures++; $display("FAIL vga_ovr_single got=%b exp=0", oVGA_OVR); end
  endtask

  task automatic test_client_write();
    logic ack, err, setup_ok, hold_ok;
    int done_cyc, we_first, we_cnt, oe_cnt;
    logic [15:0] rdata;
    logic [19:0] addr_we;
    preload(20'h190C8, 16'h0000);
    run_client(1'b1, 10'd100, 10'd200, 16'hFFFF, ack, done_cyc, err, rdata,
               we_first, we_cnt, oe_cnt, addr_we, setup_ok, hold_ok);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL wr_ack got=%b exp=1", ack); end
    checks++; if (setup_ok !== 1'b1) begin failures++; $display("FAIL wr_setup got=%b exp=1", setup_ok); end
    checks++; if (we_first !== 2) begin failures++; $display("FAIL wr_pulse_cycle got=%0d exp=2", we_first); end
    checks++; if (we_cnt !== 1) begin failures++; $display("FAIL wr_pulse_width got=%0d exp=1", we_cnt); end
    checks++; if (addr_we !== 20'h190C8) begin failures++; $display("FAIL wr_addr got=%h exp=190c8", addr_we); end
    checks++; if (hold_ok !== 1'b1) begin failures++; $display("FAIL wr_hold got=%b exp=1", hold_ok); end
    checks++; if (oe_cnt !== 0) begin failures++; $display("FAIL wr_oe_low got=%0d exp=0", oe_cnt); end
    checks++; if (done_cyc !== 4) begin failures++; $display("FAIL wr_done_cycle got=%0d exp=4", done_cyc); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", err); end
    checks++; if (mem[20'h190C8] !== 16'hFFFF) begin failures++; $display("FAIL wr_mem got=%h exp=ffff", mem[20'h190C8]); end
    run_client(1'b0, 10'd100, 10'd200, 16'h0000, ack, done_cyc, err, rdata,
               we_first, we_cnt, oe_cnt, addr_we, setup_ok, hold_ok);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL rd_ack got=%b exp=1", ack); end
    checks++; if (done_cyc !== 3) begin failures++; $display("FAIL rd_done_cycle got=%0d exp=3", done_cyc); end
    checks++; if (rdata !== 16'hFFFF) begin failures++; $display("FAIL rd_data got=%h exp=ffff", rdata); end
    checks++; if (oe_cnt !== 2) begin failures++; $display("FAIL rd_oe_cycles got=%0d exp=2", oe_cnt); end
    checks++; if (we_cnt !== 0) begin failures++; $display("FAIL rd_we_low got=%0d exp=0", we_cnt); end
  endtask

  task automatic test_starvation();
    int ack_cyc, vcnt, done_cyc, post_valid;
    logic [15:0] rdata, post_data;
    ack_cyc = -1; vcnt = 0; done_cyc = -1; post_valid = -1; rdata = '0; post_data = '0;
    preload(20'h00009, 16'h0909);
    preload(20'h00401, 16'h5A5A);
    iVGA_X = 10'd0; iVGA_Y = 10'd9;
    iWE = 1'b0; iX = 10'd1; iY = 10'd1;
    for (int c = 0; c < 30; c++) begin
      iVGA_REQ = (ack_cyc < 0);
      iREQ     = (ack_cyc < 0);
      #1;
      if (oACK && ack_cyc < 0) ack_cyc = c;
      if (oVGA_VALID) begin
        if (ack_cyc < 0 || c == ack_cyc) vcnt++;
        else if (post_valid < 0) begin post_valid = c; post_data = oVGA_DATA; end
      end
      if (oDONE && done_cyc < 0) begin done_cyc = c; rdata = oRDATA; end
      @(negedge iCLK);
    end
    iVGA_REQ = 1'b0; iREQ = 1'b0; iX = '0; iY = '0;
    checks++; if (ack_cyc !== 12) begin failures++; $display("FAIL starve_ack_cycle got=%0d exp=12", ack_cyc); end
    checks++; if (vcnt !== 4) begin failures++; $display("FAIL starve_vga_grants got=%0d exp=4", vcnt); end
    checks++; if (oVGA_OVR !== 1'b1) begin failures++; $display("FAIL starve_ovr got=%b exp=1", oVGA_OVR); end
    checks++; if (done_cyc !== 15) begin failures++; $display("FAIL starve_done_cycle got=%0d exp=15", done_cyc); end
    checks++; if (rdata !== 16'h5A5A) begin failures++; $display("FAIL starve_rdata got=%h exp=5a5a", rdata); end
    checks++; if (post_valid !== 18) begin failures++; $display("FAIL starve_pending_kept got=%0d exp=18", post_valid); end
    checks++; if (post_data !== 16'h0909) begin failures++; $display("FAIL starve_pending_data got=%h exp=0909", post_data); end
  endtask

  task automatic test_out_of_range();
    logic ack, err, setup_ok, hold_ok;
    int done_cyc, we_first, we_cnt, oe_cnt;
    logic [15:0] rdata;
    logic [19:0] addr_we;
    preload(20'hA0000, 16'h1234);
    run_client(1'b1, 10'd640, 10'd0, 16'hBEEF, ack, done_cyc, err, rdata,
               we_first, we_cnt, oe_cnt, addr_we, setup_ok, hold_ok);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL oor_ack got=%b exp=1", ack); end
    checks++; if (done_cyc !== 1) begin failures++; $display("FAIL oor_done_cycle got=%0d exp=1", done_cyc); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", err); end
    checks++; if (we_cnt !== 0) begin failures++; $display("FAIL oor_we_low got=%0d exp=0", we_cnt); end
    checks++; if (oe_cnt !== 0) begin failures++; $display("FAIL oor_oe_low got=%0d exp=0", oe_cnt); end
    checks++; if (mem[20'hA0000] !== 16'h1234) begin failures++; $display("FAIL oor_mem got=%h exp=1234", mem[20'hA0000]); end
    run_client(1'b0, 10'd0, 10'd480, 16'h0000, ack, done_cyc, err, rdata,
               we_first, we_cnt, oe_cnt, addr_we, setup_ok, hold_ok);
    checks++; if (err !== 1'b1 || done_cyc !== 1) begin failures++; $display("FAIL oor_y_read got=err%b/cyc%0d exp=err1/cyc1", err, done_cyc); end
  endtask

  task automatic test_same_cycle();
    int ack_cyc, valid_cyc, done_cyc;
    logic ack0;
    logic [15:0] vdata, rdata;
    ack_cyc = -1; valid_cyc = -1; done_cyc = -1; vdata = '0; rdata = '0; ack0 = 1'b0;
    preload(20'h00C04, 16'h0C0C);
    preload(20'h00802, 16'h2222);
    iVGA_REQ = 1'b1; iVGA_X = 10'd3; iVGA_Y = 10'd4;
    iREQ = 1'b1; iWE = 1'b0; iX = 10'd2; iY = 10'd2;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        iVGA_REQ = 1'b0;
        if (ack_cyc >= 0) iREQ = 1'b0;
      end
      #1;
      if (c == 0) ack0 = oACK;
      if (oACK && ack_cyc < 0) ack_cyc = c;
      if (oVGA_VALID && valid_cyc < 0) begin valid_cyc = c; vdata = oVGA_DATA; end
      if (oDONE && done_cyc < 0) begin done_cyc = c; rdata = oRDATA; end
      @(negedge iCLK);
    end
    iREQ = 1'b0; iX = '0; iY = '0;
    checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL same_vga_first got=%b exp=0", ack0); end
    checks++; if (ack_cyc !== 3) begin failures++; $display("FAIL same_ack_cycle got=%0d exp=3", ack_cyc); end
    checks++; if (valid_cyc !== 3) begin failures++; $display("FAIL same_valid_cycle got=%0d exp=3", valid_cyc); end
    checks++; if (vdata !== 16'h0C0C) begin failures++; $display("FAIL same_vga_data got=%h exp=0c0c", vdata); end
    checks++; if (done_cyc !== 6) begin failures++; $display("FAIL same_done_cycle got=%0d exp=6", done_cyc); end
    checks++; if (rdata !== 16'h2222) begin failures++; $display("FAIL same_rdata got=%h exp=2222", rdata); end
  endtask

  task automatic test_reset_mid_write();
    logic ack, err, setup_ok, hold_ok, ack_a, we_mid;
    int done_cyc, we_first, we_cnt, oe_cnt, dn;
    logic [15:0] rdata;
    logic [19:0] addr_we;
    dn = 0;
    preload(20'h190C8, 16'h0000);
    iREQ = 1'b1; iWE = 1'b1; iX = 10'd10; iY = 10'd20; iWDATA = 16'h1357;
    #1 ack_a = oACK;
    @(negedge iCLK);
    iREQ = 1'b0; iWE = 1'b0; iX = '0; iY = '0; iWDATA = '0;
    @(negedge iCLK);
    we_mid = oSRAM_WE_N;
    #1 iRST = 1'b1;
    #1;
    checks++; if (ack_a !== 1'b1 || we_mid !== 1'b0) begin failures++; $display("FAIL rst_reach_pulse got=ack%b/we_n%b exp=ack1/we_n0", ack_a, we_mid); end
    checks++; if (oSRAM_WE_N !== 1'b1) begin failures++; $display("FAIL rst_we_n_immediate got=%b exp=1", oSRAM_WE_N); end
    checks++; if (oSRAM_DQ_OE !== 1'b0) begin failures++; $display("FAIL rst_dq_oe_immediate got=%b exp=0", oSRAM_DQ_OE); end
    checks++; if (oVGA_OVR !== 1'b0 || oSRAM_ADDR !== 20'h0) begin failures++; $display("FAIL rst_state got=ovr%b/addr%h exp=ovr0/addr00000", oVGA_OVR, oSRAM_ADDR); end
    @(negedge iCLK);
    iRST = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (oDONE) dn++;
      @(negedge iCLK);
    end
    checks++; if (dn !== 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", dn); end
    run_client(1'b1, 10'd100, 10'd200, 16'h0F0F, ack, done_cyc, err, rdata,
               we_first, we_cnt, oe_cnt, addr_we, setup_ok, hold_ok);
    checks++; if (ack !== 1'b1 || setup_ok !== 1'b1 || hold_ok !== 1'b1) begin failures++; $display("FAIL rst_after_frame got=ack%b/setup%b/hold%b exp=111", ack, setup_ok, hold_ok); end
    checks++; if (we_first !== 2 || we_cnt !== 1) begin failures++; $display("FAIL rst_after_pulse got=first%0d/cnt%0d exp=2/1", we_first, we_cnt); end
    checks++; if (done_cyc !== 4 || err !== 1'b0) begin failures++; $display("FAIL rst_after_done got=cyc%0d/err%b exp=4/0", done_cyc, err); end
    checks++; if (mem[20'h190C8] !== 16'h0F0F) begin failures++; $display("FAIL rst_after_mem got=%h exp=0f0f", mem[20'h190C8]); end
  endtask

  task automatic test_invariants();
    checks++; if (viol !== 0) begin failures++; $display("FAIL bus_invariants got=%0d violations exp=0", viol); end
  endtask

  initial begin
    iRST = 1'b0; iVGA_REQ = 1'b0; iVGA_X = '0; iVGA_Y = '0;
    iREQ = 1'b0; iWE = 1'b0; iX = '0; iY = '0; iWDATA = '0;
    #1;
    test_reset();
    test_vga_fetch();
    test_client_write();
    test_starvation();
    test_out_of_range();
    test_same_cycle();
    test_reset_mid_write();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
